split_assign_driver: RTL

- Transmit-side counterpart to the generated split_N constraint checkers.
- Accepts a stream of (variable index, value) writes and holds them in a register bank that drives a checker's var_* inputs as one flat bus.
- On the last write of a batch it waits a fixed settle latency, samples the checker's single-bit verdict and returns it over a valid/ready result channel.
- Sits between the solver's assignment enumerator and each split instance.

---
 rtl/split_assign_driver.sv | 120 ++++++++++++
 1 files changed

// File: rtl/split_assign_driver.sv
// split_assign_driver
//   Transmit-side driver for a split_N constraint checker. Accepts a stream of
//   (slot index, value) writes into a register bank that drives the checker's
//   var_* inputs as one flat bus. When the last beat of a batch is accepted it
//   waits CHECK_LAT settle cycles, samples the checker verdict and returns it
//   on a valid/ready result channel.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   wr_valid   write beat valid
//   wr_ready   write beat accepted when wr_valid && wr_ready (high only in LOAD)
//   wr_id      target slot index
//   wr_data    slot value
//   wr_last    final beat of the batch, starts the check
//   vars_flat  registered slot bank, slot k at [k*VAR_W +: VAR_W]
//   chk_x      checker verdict, 1 = satisfied
//   res_valid  verdict available (REPORT state)
//   res_ready  verdict consumed when res_valid && res_ready
//   res_sat    sampled chk_x
//   res_err    an out-of-range wr_id was seen in this batch
//   busy       high while waiting for or reporting a verdict
module split_assign_driver #(
  parameter int NUM_VARS  = 150,
  parameter int VAR_W     = 16,
  parameter int ID_W      = 8,
  parameter int CHECK_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [ID_W-1:0]           wr_id,
  input  logic [VAR_W-1:0]          wr_data,
  input  logic                      wr_last,
  output logic [NUM_VARS*VAR_W-1:0] vars_flat,
  input  logic                      chk_x,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_sat,
  output logic                      res_err,
  output logic                      busy
);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_WAIT   = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  // One extra bit so the compare stays correct when NUM_VARS == 2^ID_W.
  localparam logic [ID_W:0] ID_LIM = (ID_W+1)'(NUM_VARS);
  localparam logic [3:0]    LAT    = 4'(CHECK_LAT);

  state_t                      state;
  logic [NUM_VARS*VAR_W-1:0]   bank;
  logic                        err_flag;
  logic [3:0]                  cnt;
  logic                        id_ok;

  assign id_ok = ({1'b0, wr_id} < ID_LIM);

  // Outputs decode the state register only, so there is no combinational
  // path from chk_x or res_ready to any output.
  assign wr_ready  = (state == S_LOAD);
  assign busy      = (state != S_LOAD);
  assign res_valid = (state == S_REPORT);
  assign vars_flat = bank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_LOAD;
      bank     <= '0;
      err_flag <= 1'b0;
      cnt      <= '0;
      res_sat  <= 1'b0;
      res_err  <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (wr_valid) begin
            // Out-of-range ids match no slot, so their data is dropped.
            for (int k = 0; k < NUM_VARS; k++) begin
              if (wr_id == ID_W'(k)) begin
                bank[k*VAR_W +: VAR_W] <= wr_data;
              end
            end
            if (!id_ok) begin
              err_flag <= 1'b1;
            end
            if (wr_last) begin
              cnt   <= LAT;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            res_sat <= chk_x;
            res_err <= err_flag;
            state   <= S_REPORT;
          end
        end
        S_REPORT: begin
          // res_sat/res_err hold their value past the handshake.
          if (res_ready) begin
            err_flag <= 1'b0;
            state    <= S_LOAD;
          end
        end
        default: begin
          state <= S_LOAD;
        end
      endcase
    end
  end

endmodule
